fifo_stream_reader: RTL

- Downstream drain stage for the team's 8-deep synchronous FIFO.
- Drives the FIFO read/empty interface, which has a one-cycle registered read latency. Converts it into a fully registered valid/ready stream with packet framing (out_last every pkt_len words).
- Sustains one word per cycle under continuous ready.
- Has no combinational path from out_ready to fifo_read.

---
 rtl/fifo_stream_reader.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// fifo_stream_reader: drains a one-cycle-latency FIFO read port into a registered
// valid/ready stream with out_last framing every pkt_len words.
module fifo_stream_reader #(
    parameter int WIDTH    = 16,
    parameter int LEN_BITS = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                fifo_empty,
    input  logic [WIDTH-1:0]    fifo_data,
    output logic                fifo_read,
    input  logic [LEN_BITS-1:0] pkt_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last
);

    logic [WIDTH-1:0]    buf_q [3];
    logic [1:0]          head_q, head_d;
    logic [1:0]          tail_q, tail_d;
    logic [1:0]          count_q, count_d;
    logic                in_flight_q, in_flight_d;
    logic [LEN_BITS-1:0] word_cnt_q, word_cnt_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] len_m1;
    logic [2:0]          credit_used;
    logic                capture;
    logic                pop;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue a read only when the buffer can absorb it even if nothing pops,
    // so out_ready never reaches fifo_read combinationally.
    always_comb begin
        credit_used = {1'b0, count_q} + {2'b00, in_flight_q};
        fifo_read   = reset_n & ~fifo_empty & ~flush & (credit_used < 3'd3);
        out_valid   = (count_q != 2'd0);
        out_data    = out_valid ? buf_q[head_q] : '0;
        len_m1      = len_q - LEN_BITS'(1);
        out_last    = out_valid & (word_cnt_q == len_m1);
        capture     = in_flight_q & ~flush;
        pop         = out_valid & out_ready & ~flush;
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        in_flight_d = fifo_read;
        word_cnt_d  = word_cnt_q;
        len_d       = (word_cnt_q == '0) ? pkt_len : len_q;

        if (flush) begin
            head_d      = 2'd0;
            tail_d      = 2'd0;
            count_d     = 2'd0;
            word_cnt_d  = '0;
            in_flight_d = 1'b0;
        end else begin
            if (capture) begin
                tail_d = wrap_inc(tail_q);
            end
            if (pop) begin
                head_d     = wrap_inc(head_q);
                word_cnt_d = out_last ? '0 : word_cnt_q + LEN_BITS'(1);
            end
            case ({capture, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= 2'd0;
            tail_q      <= 2'd0;
            count_q     <= 2'd0;
            in_flight_q <= 1'b0;
            word_cnt_q  <= '0;
            len_q       <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
        end
    end

    // Storage needs no reset: count_q gates every observation of it.
    always_ff @(posedge clock) begin
        if (capture) begin
            buf_q[tail_q] <= fifo_data;
        end
    end

endmodule
`default_nettype wire
